// File: rtl/bpsk_frame_serializer.sv
// bpsk_frame_serializer
// Captures a packet word over a valid/ready handshake, then emits a full frame
// bit-serially, one bit per bit_strobe: alternating preamble, sync word,
// payload (MSB- or LSB-first), then an inter-frame gap of idle zeros.
//
// Ports:
//   clk        system clock, all state on rising edge
//   rst        asynchronous active-high reset
//   pkt_data   packet to send, sampled only on handshake
//   pkt_valid  source has a packet
//   pkt_ready  block can accept a packet (IDLE only, low while rst=1)
//   bit_strobe single-cycle bit-rate tick
//   tx_bit     serial output bit to the modulator phase select (registered)
//   tx_active  high while preamble/sync/payload bits are on tx_bit (registered)
//   frame_done one-cycle pulse with the last payload bit (registered)
module bpsk_frame_serializer #(
    parameter int unsigned             PACKET_WIDTH = 32,
    parameter int unsigned             PREAMBLE_LEN = 16,
    parameter int unsigned             SYNC_WIDTH   = 8,
    parameter logic [SYNC_WIDTH-1:0]   SYNC_WORD    = SYNC_WIDTH'(8'hA7),
    parameter bit                      LSB_FIRST    = 1'b0,
    parameter int unsigned             GAP_BITS     = 4
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic [PACKET_WIDTH-1:0] pkt_data,
    input  logic                    pkt_valid,
    output logic                    pkt_ready,
    input  logic                    bit_strobe,
    output logic                    tx_bit,
    output logic                    tx_active,
    output logic                    frame_done
);

    // Counter sized for the longest segment so it never wraps mid-segment.
    localparam int unsigned SEG_AB  = (PREAMBLE_LEN > SYNC_WIDTH) ? PREAMBLE_LEN : SYNC_WIDTH;
    localparam int unsigned SEG_CD  = (PACKET_WIDTH > GAP_BITS) ? PACKET_WIDTH : GAP_BITS;
    localparam int unsigned SEG_MAX = (SEG_AB > SEG_CD) ? SEG_AB : SEG_CD;
    localparam int unsigned CNT_W   = $clog2(SEG_MAX) + 1;

    // Last counter value of each segment. The gap state always lasts at least
    // one strobe: with GAP_BITS=0 that strobe just returns tx_bit to idle.
    localparam int unsigned PRE_LAST  = (PREAMBLE_LEN > 0) ? PREAMBLE_LEN - 1 : 0;
    localparam int unsigned SYNC_LAST = SYNC_WIDTH - 1;
    localparam int unsigned PAY_LAST  = PACKET_WIDTH - 1;
    localparam int unsigned GAP_LAST  = (GAP_BITS > 0) ? GAP_BITS - 1 : 0;

    typedef enum logic [2:0] {
        S_IDLE,
        S_PREAMBLE,
        S_SYNC,
        S_PAYLOAD,
        S_GAP
    } state_e;

    state_e                  state_q, state_d;
    logic [CNT_W-1:0]        cnt_q, cnt_d;
    logic [PACKET_WIDTH-1:0] shift_q, shift_d;
    logic                    tx_bit_q, tx_bit_d;
    logic                    tx_active_q, tx_active_d;
    logic                    frame_done_q, frame_done_d;
    logic [SYNC_WIDTH-1:0]   sync_shifted;

    // Next-state and output computation.
    always_comb begin
        state_d      = state_q;
        cnt_d        = cnt_q;
        shift_d      = shift_q;
        tx_bit_d     = tx_bit_q;
        tx_active_d  = tx_active_q;
        frame_done_d = 1'b0;
        // Sync bit i sits at the MSB after shifting the word left by i.
        sync_shifted = SYNC_WORD << cnt_q;

        case (state_q)
            S_IDLE: begin
                // A strobe in the acceptance cycle is deliberately ignored.
                if (pkt_valid) begin
                    shift_d = pkt_data;
                    cnt_d   = '0;
                    state_d = (PREAMBLE_LEN > 0) ? S_PREAMBLE : S_SYNC;
                end
            end
            S_PREAMBLE: begin
                if (bit_strobe) begin
                    tx_bit_d    = ~cnt_q[0];
                    tx_active_d = 1'b1;
                    if (cnt_q == CNT_W'(PRE_LAST)) begin
                        cnt_d   = '0;
                        state_d = S_SYNC;
                    end else begin
                        cnt_d = cnt_q + CNT_W'(1);
                    end
                end
            end
            S_SYNC: begin
                if (bit_strobe) begin
                    tx_bit_d    = sync_shifted[SYNC_WIDTH-1];
                    tx_active_d = 1'b1;
                    if (cnt_q == CNT_W'(SYNC_LAST)) begin
                        cnt_d   = '0;
                        state_d = S_PAYLOAD;
                    end else begin
                        cnt_d = cnt_q + CNT_W'(1);
                    end
                end
            end
            S_PAYLOAD: begin
                if (bit_strobe) begin
                    tx_bit_d    = LSB_FIRST ? shift_q[0] : shift_q[PACKET_WIDTH-1];
                    shift_d     = LSB_FIRST ? (shift_q >> 1) : (shift_q << 1);
                    tx_active_d = 1'b1;
                    if (cnt_q == CNT_W'(PAY_LAST)) begin
                        frame_done_d = 1'b1;
                        cnt_d        = '0;
                        state_d      = S_GAP;
                    end else begin
                        cnt_d = cnt_q + CNT_W'(1);
                    end
                end
            end
            S_GAP: begin
                if (bit_strobe) begin
                    tx_bit_d    = 1'b0;
                    tx_active_d = 1'b0;
                    if (cnt_q == CNT_W'(GAP_LAST)) begin
                        cnt_d   = '0;
                        state_d = S_IDLE;
                    end else begin
                        cnt_d = cnt_q + CNT_W'(1);
                    end
                end
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    // State and output registers.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q      <= S_IDLE;
            cnt_q        <= '0;
            shift_q      <= '0;
            tx_bit_q     <= 1'b0;
            tx_active_q  <= 1'b0;
            frame_done_q <= 1'b0;
        end else begin
            state_q      <= state_d;
            cnt_q        <= cnt_d;
            shift_q      <= shift_d;
            tx_bit_q     <= tx_bit_d;
            tx_active_q  <= tx_active_d;
            frame_done_q <= frame_done_d;
        end
    end

    // Ready is a decode of the registered state, gated low during reset.
    assign pkt_ready  = (state_q == S_IDLE) && !rst;
    assign tx_bit     = tx_bit_q;
    assign tx_active  = tx_active_q;
    assign frame_done = frame_done_q;

endmodule
